// File: rtl/py_seq_if.sv
// py_seq_if: controls from the packet controller and phase/strobe outputs to the payload bit processor.
// abort_p is present only when PY_SEQ_ABORT_EN is defined.
interface py_seq_if #(
   parameter int LENW = 10
);
   logic            p_1us;
   logic            start_p;
   logic            pk_encode;
   logic [LENW-1:0] py_len;
   logic            crc_en;
   logic            fec32encode;
`ifdef PY_SEQ_ABORT_EN
   logic            abort_p;
`endif
   logic            py_st_p;
   logic            py_period;
   logic            py_datperiod;
   logic            py_crc16period;
   logic            daten;
   logic            py_datvalid_p;
   logic            fec32bk_endp;
   logic            py_endp;
   logic            busy;

   modport master (
      output p_1us, start_p, pk_encode, py_len, crc_en, fec32encode,
`ifdef PY_SEQ_ABORT_EN
      output abort_p,
`endif
      input  py_st_p, py_period, py_datperiod, py_crc16period, daten,
      input  py_datvalid_p, fec32bk_endp, py_endp, busy
   );

   modport slave (
      input  p_1us, start_p, pk_encode, py_len, crc_en, fec32encode,
`ifdef PY_SEQ_ABORT_EN
      input  abort_p,
`endif
      output py_st_p, py_period, py_datperiod, py_crc16period, daten,
      output py_datvalid_p, fec32bk_endp, py_endp, busy
   );
endinterface

// File: rtl/py_seq.sv
// py_seq: payload bit sequencer (start, data, CRC16, FEC pad, FEC parity) driven by the p_1us bit strobe.
// Define PY_SEQ_ABORT_EN to add the abort_p input.
module py_seq #(
   parameter int LENW = 10,
   parameter int BCW  = 14
) (
   input  logic    clk_6M,
   input  logic    rst,
   py_seq_if.slave py
);
   typedef enum logic [2:0] {IDLE, START, DATA, CRC, PAD, DONE} state_t;

   state_t          state;
   logic            crc_q, fec_q;
   logic [LENW-1:0] len_q;
   logic [BCW-1:0]  bc;
   logic [3:0]      slot;

   logic [BCW-1:0]  n_dat, n_info, bc_n;
   logic [3:0]      slot_n;
   logic            info_slot, info_next, final_bit, kill, adv, period;
   state_t          ph_first, ph_next;

   // TX and RX walk the same phase sequence; direction only matters to the bit processor.
   logic unused_enc;
   assign unused_enc = py.pk_encode;

`ifdef PY_SEQ_ABORT_EN
   assign kill = rst | py.abort_p;
`else
   assign kill = rst;
`endif

   assign n_dat  = BCW'({len_q, 3'b000});
   assign n_info = n_dat + (crc_q ? BCW'(16) : BCW'(0));

   assign period    = (state == START) | (state == DATA) | (state == CRC) | (state == PAD);
   assign adv       = py.p_1us & period & (state != START) & ~kill;
   assign info_slot = ~fec_q | (slot < 4'd10);
   assign bc_n      = bc + BCW'(info_slot);
   assign slot_n    = (~fec_q || slot == 4'd14) ? 4'd0 : slot + 4'd1;
   assign info_next = ~fec_q | (slot_n < 4'd10);
   // With FEC the payload ends on a block boundary once every info bit (incl. pad) is out.
   assign final_bit = fec_q ? ((slot == 4'd14) && (bc >= n_info)) : (bc_n == n_info);

   assign ph_first = (n_dat != '0) ? DATA : CRC;
   assign ph_next  = (bc_n < n_dat) ? DATA : (bc_n < n_info) ? CRC : PAD;

   assign py.py_st_p        = (state == START);
   assign py.py_period      = period;
   assign py.py_datperiod   = (state == DATA);
   assign py.py_crc16period = (state == CRC);
   assign py.daten          = period & info_slot;
   assign py.py_datvalid_p  = adv;
   assign py.fec32bk_endp   = adv & fec_q & (slot == 4'd14);
   assign py.py_endp        = ((state == START) & (n_info == '0) & ~kill) | (adv & final_bit);
   assign py.busy           = (state != IDLE);

   always_ff @(posedge clk_6M) begin
      if (rst) begin
         state <= IDLE;
         crc_q <= 1'b0;
         fec_q <= 1'b0;
         len_q <= '0;
         bc    <= '0;
         slot  <= '0;
      end
`ifdef PY_SEQ_ABORT_EN
      else if (py.abort_p && state != IDLE) begin
         state <= IDLE;
         bc    <= '0;
         slot  <= '0;
      end
`endif
      else begin
         case (state)
            IDLE: if (py.start_p) begin
               len_q <= py.py_len;
               crc_q <= py.crc_en;
               fec_q <= py.fec32encode;
               bc    <= '0;
               slot  <= '0;
               state <= START;
            end
            START: begin
               slot  <= '0;
               state <= (n_info == '0) ? DONE : ph_first;
            end
            DATA, CRC, PAD: if (adv) begin
               bc   <= bc_n;
               slot <= slot_n;
               // Parity slots freeze the phase; it moves only when the next slot carries info.
               if (final_bit)      state <= DONE;
               else if (info_next) state <= ph_next;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_py_seq.sv
// tb_py_seq: directed bench for py_seq; records per-strobe phase outputs and checks hand-derived values.
`timescale 1ns/1ps
module tb_py_seq;
   logic clk_6M = 1'b0;
   logic rst    = 1'b1;
   always #5 clk_6M = ~clk_6M;

   py_seq_if #(.LENW(10)) ifc ();
   py_seq #(.LENW(10), .BCW(14)) dut (.clk_6M(clk_6M), .rst(rst), .py(ifc.slave));

   int checks = 0, errors = 0;
   int ndv, nendp, nbk, npad, endp_dv, endp_t, drop_t, tcnt;
   logic [63:0] dp, cp, de, bk, exp_de, exp_bk;
   logic [8:0]  outs;

   assign outs = {ifc.py_st_p, ifc.py_period, ifc.py_datperiod, ifc.py_crc16period, ifc.daten,
                  ifc.py_datvalid_p, ifc.fec32bk_endp, ifc.py_endp, ifc.busy};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      ndv = 0; nendp = 0; nbk = 0; npad = 0; endp_dv = 0; endp_t = -1; drop_t = -1; tcnt = 0;
      dp = '0; cp = '0; de = '0; bk = '0;
   endtask

   task automatic rec();
      tcnt++;
      if (ifc.py_datvalid_p) begin
         ndv++;
         if (ndv < 64) begin
            dp[ndv] = ifc.py_datperiod;
            cp[ndv] = ifc.py_crc16period;
            de[ndv] = ifc.daten;
            bk[ndv] = ifc.fec32bk_endp;
         end
         if (ifc.py_period && !ifc.py_datperiod && !ifc.py_crc16period) npad++;
      end
      if (ifc.fec32bk_endp) nbk++;
      if (ifc.py_endp) begin nendp++; endp_dv = ndv; endp_t = tcnt; end
      if (endp_t >= 0 && drop_t < 0 && !ifc.busy) drop_t = tcnt;
   endtask

   task automatic tick(input logic p, input logic s, input logic r = 1'b0);
      @(negedge clk_6M);
      ifc.p_1us = p; ifc.start_p = s; rst = r;
      #1;
      rec();
   endtask

   task automatic cfg(input int len, input logic crc, input logic fec);
      ifc.py_len = 10'(len); ifc.crc_en = crc; ifc.fec32encode = fec; ifc.pk_encode = 1'b1;
   endtask

   // strobe every 'gap' cycles until the payload ends and busy drops
   task automatic run(input int gap);
      int c = 0;
      while (!(endp_t >= 0 && drop_t >= 0) && c < 600) begin
         tick((c % gap) == 0, 1'b0);
         c++;
      end
      chk("run_completes", 64'(drop_t >= 0), 64'd1);
   endtask

   initial begin
      ifc.p_1us = 0; ifc.start_p = 0; ifc.pk_encode = 0; ifc.py_len = '0;
      ifc.crc_en = 0; ifc.fec32encode = 0;
`ifdef PY_SEQ_ABORT_EN
      ifc.abort_p = 0;
`endif
      clr();
      tick(0, 0, 1); tick(1, 1, 1);
      chk("reset_outs", outs, 9'h000);
      tick(0, 0, 0);
      chk("idle_outs", outs, 9'h000);

      // 1: len=1, no CRC, no FEC
      clr(); cfg(1, 0, 0);
      tick(0, 1);
      chk("t1_idle_busy", ifc.busy, 1'b0);
      tick(0, 0);
      chk("t1_start", {ifc.py_st_p, ifc.py_period, ifc.py_datperiod, ifc.py_crc16period, ifc.py_endp, ifc.busy}, 6'b110001);
      run(2);
      chk("t1_ndv", ndv, 8);
      chk("t1_datperiod", dp[8:1], 8'hFF);
      chk("t1_daten", de[8:1], 8'hFF);
      chk("t1_endp", {nendp, endp_dv}, {32'd1, 32'd8});
      chk("t1_nbk", nbk, 0);

      // 2: len=2 with CRC
      clr(); cfg(2, 1, 0);
      tick(0, 1); tick(0, 0);
      run(2);
      chk("t2_ndv", ndv, 32);
      chk("t2_datperiod", dp[32:1], 32'h0000FFFF);
      chk("t2_crcperiod", cp[32:1], 32'hFFFF0000);
      chk("t2_endp_bit", endp_dv, 32);
      chk("t2_busy_drop", drop_t - endp_t, 2);

      // 3: len=1, CRC, FEC: N=24 -> 6 pad bits, 3 blocks
      clr(); cfg(1, 1, 1);
      tick(0, 1); tick(0, 0);
      run(3);
      exp_de = '0; exp_bk = '0;
      for (int k = 1; k <= 45; k++) begin
         exp_de[k] = ((k - 1) % 15) < 10;
         exp_bk[k] = (k % 15) == 0;
      end
      chk("t3_ndv", ndv, 45);
      chk("t3_daten", de, exp_de);
      chk("t3_bkend", bk, exp_bk);
      chk("t3_nbk", nbk, 3);
      chk("t3_phases", {dp[8], cp[8], cp[9], cp[34], cp[35], dp[35]}, 6'b101100);
      chk("t3_pad_and_parity", npad, 11);
      chk("t3_endp_bit", endp_dv, 45);

      // FEC with N=40 already aligned: no pad, data phase held through parity
      clr(); cfg(5, 0, 1);
      tick(0, 1); tick(0, 0);
      run(2);
      chk("fa_ndv", ndv, 60);
      chk("fa_nbk", nbk, 4);
      chk("fa_npad", npad, 0);
      chk("fa_datperiod", dp, 64'h1FFF_FFFF_FFFF_FFFE);
      chk("fa_endp_bit", endp_dv, 60);

      // 4: len=0, no CRC; start_p while busy ignored
      clr(); cfg(0, 0, 0);
      tick(0, 1);
      tick(1, 1);
      chk("t4_start", {ifc.py_st_p, ifc.py_period, ifc.py_endp, ifc.py_datvalid_p}, 4'b1110);
      tick(0, 0);
      chk("t4_done", {ifc.py_st_p, ifc.py_period, ifc.busy}, 3'b001);
      tick(0, 0);
      chk("t4_idle", ifc.busy, 1'b0);
      tick(0, 0);
      chk("t4_ignored", {ifc.py_st_p, ifc.busy}, 2'b00);
      chk("t4_counts", {ndv, nendp}, {32'd0, 32'd1});

      // 5a: p_1us coincident with start_p and py_st_p is not counted
      clr(); cfg(1, 0, 0);
      tick(1, 1);
      chk("t5_start_dv", ifc.py_datvalid_p, 1'b0);
      tick(1, 0);
      chk("t5_stp_dv", {ifc.py_st_p, ifc.py_datvalid_p}, 2'b10);
      run(2);
      chk("t5_ndv", {ndv, endp_dv}, {32'd8, 32'd8});

      // 5b: rst at strobe 5 of a len=4 run
      clr(); cfg(4, 0, 0);
      tick(0, 1); tick(0, 0);
      for (int c = 0; c < 100 && ndv < 4; c++) tick((c % 2) == 0, 1'b0);
      tick(0, 0);
      tick(1, 0, 1);
      chk("t5_rst_endp", ifc.py_endp, 1'b0);
      tick(0, 0, 0);
      chk("t5_rst_outs", outs, 9'h000);
      chk("t5_no_endp", nendp, 0);

`ifdef PY_SEQ_ABORT_EN
      // 6: abort at strobe 12 of a FEC run, then a fresh run
      clr(); cfg(1, 1, 1);
      tick(0, 1); tick(0, 0);
      for (int c = 0; c < 100 && ndv < 11; c++) tick((c % 2) == 0, 1'b0);
      tick(0, 0);
      @(negedge clk_6M);
      ifc.p_1us = 1; ifc.abort_p = 1;
      #1;
      chk("t6_abort_pulses", {ifc.py_endp, ifc.fec32bk_endp, ifc.py_datvalid_p}, 3'b000);
      rec();
      @(negedge clk_6M);
      ifc.p_1us = 0; ifc.abort_p = 0;
      #1;
      chk("t6_abort_outs", outs, 9'h000);
      clr();
      tick(0, 1); tick(0, 0);
      chk("t6_restart", ifc.py_st_p, 1'b1);
      run(2);
      chk("t6_rerun", {ndv, nbk, endp_dv}, {32'd45, 32'd3, 32'd45});
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
